bcd_scan_driver: RTL
====================

// Module: bcd_scan_driver
// PURPOSE
//  Upstream feeder for the 7-segment decoder stage. Captures a binary value, converts it to BCD
//  with a sequential double-dabble engine (one bit per clock), then time-multiplexes the digits
//  onto a single 4-bit num bus and drives a one-hot digit-select bus.
//  sel is delayed one clock to line up with the decoder's registered dig output.
// PARAMETERS
//  NDIG      4      number of displayed digits (1..8)
//  VAL_W     14     width of binary input value (1..27)
//  SCAN_DIV  50000  clocks each digit is held before advancing (>=2)
// PORTS
//  clk    in   1         system clock; all logic on posedge
//  rst_n  in   1         synchronous reset, active-low
//  val    in   VAL_W     binary value to display; sampled only when load accepted
//  load   in   1         pulse: start conversion of val
//  busy   out  1         conversion in progress; load ignored while high
//  ovf    out  1         last committed value exceeded 10^NDIG-1
//  num    out  4         BCD digit to decoder (registered)
//  sel    out  NDIG      one-hot digit enable, active-high, aligned to decoder output
// BEHAVIOUR
//  Reset (rst_n=0 at a posedge): busy=0, ovf=0, num=0, sel=0, digit index=0, divider=0,
//   committed BCD=0, shift regs=0. Reset wins over every other input, mid-conversion included.
//  FSM: IDLE -> SHIFT -> COMMIT -> IDLE.
//   IDLE: load=1 captures val into shift reg, clears BCD scratch, iteration count=0, -> SHIFT.
//   SHIFT: each clock: any scratch nibble >=5 gets +3, then {scratch,shift} <<= 1; after VAL_W
//    iterations -> COMMIT. Scratch is 4*NDIG+4 bits (one guard nibble).
//   COMMIT: guard nibble !=0 -> ovf=1 and every committed nibble = 4'hE; else ovf=0 and
//    committed = low 4*NDIG scratch bits. -> IDLE.
//  busy=1 in SHIFT and COMMIT: exactly VAL_W+1 clocks after the load edge. Commit is
//   atomic: the scan never shows a partially converted value. load during busy is dropped,
//   with no queueing. load in the same cycle busy falls (COMMIT) is also dropped.
//  Scan divider counts 0..SCAN_DIV-1 continuously, independent of the FSM. At terminal count,
//   index advances; NDIG-1 wraps to 0.
//  num <= committed[index] every clock. sel <= one-hot(index of previous cycle), so sel lags
//   num by exactly 1 clock. First non-zero sel is on the 2nd clock after reset release.
//  Digit 0 = least significant, sel[0].
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: while ovf=0, any zero nibble more significant than the
//   highest non-zero nibble has its sel bit forced to 0. Digit 0 is never blanked, so value 0
//   shows "0". num is still driven as 0 for blanked digits.
//  Undefined: all NDIG digits are always enabled in turn; leading zeros are displayed.
// TESTING (NDIG=4, VAL_W=14, SCAN_DIV=4)
//  Reset with load=1 held -> busy=0, num=0, sel=0; after release sel walks 0001,0010,0100,1000
//   every 4 clocks.
//  load val=1234 -> busy high 15 clocks, then num per index = 4,3,2,1; sel one clock behind num.
//  load 1234, then load 9999 two clocks later -> second load ignored; display 1234.
//  load 12000 -> ovf=1, num=4'hE on all digits; then load 7 -> ovf=0, digits 7,0,0,0.
//  rst_n low during SHIFT for 1 clock -> all outputs return to reset values; no commit occurs.
//  LEADING_ZERO_BLANK_EN, load 42 -> sel only pulses 0001, 0010 (digits 2,4); load 0 -> only
//   sel[0], num=0.

Source files
------------

// File: rtl/bcd_scan_driver.sv
// Sequential double-dabble binary-to-BCD converter feeding a multiplexed 7-segment digit scan.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress sel for leading zero digits).
module bcd_scan_driver #(
   parameter int NDIG     = 4,
   parameter int VAL_W    = 14,
   parameter int SCAN_DIV = 50000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [VAL_W-1:0] val,
   input  logic             load,
   output logic             busy,
   output logic             ovf,
   output logic [3:0]       num,
   output logic [NDIG-1:0]  sel
);

   localparam int SCR_W = 4*NDIG + 4;
   localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(VAL_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t              state_reg, state_next;
   logic                do_load, do_shift, do_commit;
   logic [VAL_W-1:0]    shift_reg;
   logic [SCR_W-1:0]    scr_reg, scr_adj;
   logic [CNT_W-1:0]    cnt_reg;
   logic                lost_reg;
   logic [4*NDIG-1:0]   bcd_reg;
   logic                ovf_reg;
   logic [DIV_W-1:0]    div_reg;
   logic [IDX_W-1:0]    idx_reg, idx_d_reg;
   logic                run_reg;
   logic [3:0]          num_reg;
   logic                blank_reg, blank_next;
   logic [NDIG-1:0]     sel_reg;
   logic [3:0]          digit [NDIG];

   genvar gi;
   generate
      for (gi = 0; gi < NDIG + 1; gi++) begin : g_adj
         assign scr_adj[gi*4 +: 4] = (scr_reg[gi*4 +: 4] >= 4'd5) ?
                                     scr_reg[gi*4 +: 4] + 4'd3 : scr_reg[gi*4 +: 4];
      end
      for (gi = 0; gi < NDIG; gi++) begin : g_digit
         assign digit[gi] = bcd_reg[gi*4 +: 4];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (load) state_next = SHIFT;
         SHIFT:   if (cnt_reg == CNT_W'(VAL_W - 1)) state_next = COMMIT;
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_reg != IDLE);
      do_load   = (state_reg == IDLE) && load;
      do_shift  = (state_reg == SHIFT);
      do_commit = (state_reg == COMMIT);
   end

   // lost_reg catches a carry pushed out of the guard nibble when VAL_W outgrows the scratch
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_reg <= '0;
         scr_reg   <= '0;
         cnt_reg   <= '0;
         lost_reg  <= 1'b0;
         bcd_reg   <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         if (do_load) begin
            shift_reg <= val;
            scr_reg   <= '0;
            cnt_reg   <= '0;
            lost_reg  <= 1'b0;
         end
         if (do_shift) begin
            {scr_reg, shift_reg} <= {scr_adj[SCR_W-2:0], shift_reg, 1'b0};
            cnt_reg  <= cnt_reg + CNT_W'(1);
            lost_reg <= lost_reg | scr_adj[SCR_W-1];
         end
         if (do_commit) begin
            if (lost_reg || (scr_reg[SCR_W-1 -: 4] != 4'd0)) begin
               ovf_reg <= 1'b1;
               bcd_reg <= {NDIG{4'hE}};
            end else begin
               ovf_reg <= 1'b0;
               bcd_reg <= scr_reg[4*NDIG-1:0];
            end
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [NDIG-1:0] blank_mask;
   always_comb begin
      logic zero_run;
      zero_run   = 1'b1;
      blank_mask = '0;
      for (int i = NDIG - 1; i > 0; i--) begin
         zero_run      = zero_run && (digit[i] == 4'd0);
         blank_mask[i] = zero_run;
      end
   end
   assign blank_next = !ovf_reg && blank_mask[idx_reg];
`else
   assign blank_next = 1'b0;
`endif

   // sel follows num by one clock so it lines up with the decoder's registered output
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_reg   <= '0;
         idx_reg   <= '0;
         idx_d_reg <= '0;
         run_reg   <= 1'b0;
         num_reg   <= '0;
         blank_reg <= 1'b0;
         sel_reg   <= '0;
      end else begin
         if (div_reg == DIV_W'(SCAN_DIV - 1)) begin
            div_reg <= '0;
            idx_reg <= (idx_reg == IDX_W'(NDIG - 1)) ? '0 : idx_reg + IDX_W'(1);
         end else begin
            div_reg <= div_reg + DIV_W'(1);
         end
         idx_d_reg <= idx_reg;
         run_reg   <= 1'b1;
         num_reg   <= digit[idx_reg];
         blank_reg <= blank_next;
         sel_reg   <= (run_reg && !blank_reg) ? (NDIG'(1) << idx_d_reg) : '0;
      end
   end

   assign ovf = ovf_reg;
   assign num = num_reg;
   assign sel = sel_reg;

endmodule
